// File: rtl/mem_arbiter_if.sv
// Bus bundle joining the I-side and D-side requesters, the burst arbiter and the shared data_ram.
// The arbiter connects through the slave modport; requesters and memory model sit on the master side.
interface mem_arbiter_if;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_gnt;
  logic        i_wnext;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_done;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_wnext;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_done;

  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, d_req, d_we, d_addr, d_wdata, mem_dout, mem_ack,
    output i_gnt, i_wnext, i_rvalid, i_rdata, i_done,
    output d_gnt, d_wnext, d_rvalid, d_rdata, d_done,
    output mem_cs, mem_we, mem_addr, mem_din
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, d_req, d_we, d_addr, d_wdata, mem_dout, mem_ack,
    input  i_gnt, i_wnext, i_rvalid, i_rdata, i_done,
    input  d_gnt, d_wnext, d_rvalid, d_rdata, d_done,
    input  mem_cs, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port whole-line burst arbiter in front of data_ram (cs/ack beats, one-cycle gap between beats).
// Define ARB_RR_EN to replace fixed D-over-I tie breaking with round-robin on rr_last.
module mem_arbiter #(
  parameter int BURST_LEN  = 4,
  parameter int LINE_OFF_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int              CNT_W     = LINE_OFF_W - 2;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    BEAT  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   owner_r;   // 1 = D-port owns the burst
  logic                   we_r;
  logic [31-LINE_OFF_W:0] line_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   any_req_s;
  logic                   pick_d_s;
  logic                   busy_s;
  logic                   beat_ack_s;
  logic                   last_beat_s;
  logic                   unused_addr_s;

  assign any_req_s   = bus.i_req | bus.d_req;
  assign busy_s      = (state_r != IDLE);
  assign beat_ack_s  = (state_r == BEAT) & bus.mem_ack;
  assign last_beat_s = (cnt_r == LAST_BEAT);
  assign unused_addr_s = ^{bus.i_addr[LINE_OFF_W-1:0], bus.d_addr[LINE_OFF_W-1:0]};

`ifdef ARB_RR_EN
  logic rr_last_r;  // 1 = D was granted last

  // Round-robin history, refreshed once per granted burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_r <= 1'b0;
    end else if (state_r == SETUP) begin
      rr_last_r <= owner_r;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

  assign pick_d_s = (bus.d_req & bus.i_req) ? ~rr_last_r : bus.d_req;
`else
  assign pick_d_s = bus.d_req;
`endif

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:  state_nxt_s = any_req_s ? SETUP : IDLE;
      SETUP: state_nxt_s = BEAT;
      BEAT: begin
        if (beat_ack_s) begin
          state_nxt_s = last_beat_s ? DONE : GAP;
        end else begin
          state_nxt_s = BEAT;
        end
      end
      GAP:   state_nxt_s = BEAT;
      DONE:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus burst context captured at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      we_r    <= 1'b0;
      line_r  <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && any_req_s) begin
        owner_r <= pick_d_s;
        we_r    <= pick_d_s ? bus.d_we : bus.i_we;
        line_r  <= pick_d_s ? bus.d_addr[31:LINE_OFF_W] : bus.i_addr[31:LINE_OFF_W];
        cnt_r   <= '0;
      end else if (beat_ack_s && !last_beat_s) begin
        cnt_r   <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r   <= cnt_r;
      end
    end
  end

  // Beat field sits below the line tag, so it wraps inside the line and never carries.
  assign bus.mem_cs   = (state_r == BEAT);
  assign bus.mem_we   = busy_s & we_r;
  assign bus.mem_addr = busy_s ? {line_r, cnt_r, 2'b00} : 32'd0;
  assign bus.mem_din  = busy_s ? (owner_r ? bus.d_wdata : bus.i_wdata) : 32'd0;

  assign bus.i_gnt    = busy_s & ~owner_r;
  assign bus.d_gnt    = busy_s &  owner_r;
  assign bus.i_rvalid = beat_ack_s & ~we_r & ~owner_r;
  assign bus.d_rvalid = beat_ack_s & ~we_r &  owner_r;
  assign bus.i_wnext  = beat_ack_s &  we_r & ~owner_r;
  assign bus.d_wnext  = beat_ack_s &  we_r &  owner_r;
  assign bus.i_done   = (state_r == DONE) & ~owner_r;
  assign bus.d_done   = (state_r == DONE) &  owner_r;
  assign bus.i_rdata  = bus.mem_dout;
  assign bus.d_rdata  = bus.mem_dout;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized bursts,
// checked against a transaction-level model of expected beats, data and grants.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.BURST_LEN(4), .LINE_OFF_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int cyc; bit port; bit we; logic [31:0] addr; logic [31:0] data; } beat_t;
  typedef struct { int cyc; bit port; logic [31:0] data; } ev_t;

  beat_t       beats[$];
  ev_t         rvs[$], wns[$], dones[$], gnts[$];
  int          n_cmp = 0, n_err = 0, cyc = 0, viol = 0, ack_mode = 0, cs_cnt = 0;
  int          i_idx = 0, d_idx = 0;
  bit          i_adv = 1'b0, d_adv = 1'b0, model_last = 1'b0;
  logic [31:0] i_words[4], d_words[4];
  logic [31:0] dout_drv = 32'd0;
  logic        prev_i_gnt = 1'b0, prev_d_gnt = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Requester write-data advance and memory responder, updated just after each edge.
  initial forever begin
    @(posedge clk); #1;
    if (i_adv) begin i_idx = i_idx + 1; bus.i_wdata = i_words[i_idx[1:0]]; i_adv = 1'b0; end
    if (d_adv) begin d_idx = d_idx + 1; bus.d_wdata = d_words[d_idx[1:0]]; d_adv = 1'b0; end
    dout_drv = $urandom;
    bus.mem_dout = dout_drv;
    case (ack_mode)
      0: bus.mem_ack = 1'b1;
      1: begin
        if (bus.mem_cs) begin cs_cnt = cs_cnt + 1; bus.mem_ack = (cs_cnt % 3 == 0); end
        else bus.mem_ack = 1'b0;
      end
      default: bus.mem_ack = 1'($urandom_range(0, 1));
    endcase
  end

  // Event recorder sampled mid-cycle.
  initial begin
    beat_t b;
    ev_t   e;
    forever begin
      @(negedge clk);
      if (bus.mem_cs && bus.mem_ack) begin
        b.cyc = cyc; b.port = bus.d_gnt; b.we = bus.mem_we; b.addr = bus.mem_addr;
        b.data = bus.mem_we ? bus.mem_din : dout_drv;
        beats.push_back(b);
      end
      e.cyc = cyc;
      if (bus.i_rvalid) begin e.port = 1'b0; e.data = bus.i_rdata; rvs.push_back(e); end
      if (bus.d_rvalid) begin e.port = 1'b1; e.data = bus.d_rdata; rvs.push_back(e); end
      if (bus.i_wnext)  begin e.port = 1'b0; e.data = bus.mem_din; wns.push_back(e); i_adv = 1'b1; end
      if (bus.d_wnext)  begin e.port = 1'b1; e.data = bus.mem_din; wns.push_back(e); d_adv = 1'b1; end
      if (bus.i_done)   begin e.port = 1'b0; e.data = 32'd0; dones.push_back(e); end
      if (bus.d_done)   begin e.port = 1'b1; e.data = 32'd0; dones.push_back(e); end
      if (bus.i_gnt && !prev_i_gnt) begin e.port = 1'b0; gnts.push_back(e); end
      if (bus.d_gnt && !prev_d_gnt) begin e.port = 1'b1; gnts.push_back(e); end
      if (bus.i_gnt && bus.d_gnt) viol++;
      if (bus.mem_cs && !(bus.i_gnt || bus.d_gnt)) viol++;
      if ((bus.i_rvalid || bus.i_wnext || bus.i_done) && !bus.i_gnt) viol++;
      if ((bus.d_rvalid || bus.d_wnext || bus.d_done) && !bus.d_gnt) viol++;
      prev_i_gnt = bus.i_gnt;
      prev_d_gnt = bus.d_gnt;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    beats.delete(); rvs.delete(); wns.delete(); dones.delete(); gnts.delete();
  endtask

  task automatic wait_dones(input int n, input int budget, output bit timed_out);
    int k = 0;
    while (dones.size() < n && k < budget) begin tick(); k++; end
    timed_out = (dones.size() < n);
  endtask

  task automatic wait_beats(input int n, input int budget, output bit timed_out);
    int k = 0;
    while (beats.size() < n && k < budget) begin tick(); k++; end
    timed_out = (beats.size() < n);
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k);
    return (a & 32'hFFFF_FFF0) + 32'(4 * k);
  endfunction

  task automatic test_reset();
    logic [9:0] flags;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    flags = {bus.i_gnt, bus.d_gnt, bus.mem_cs, bus.mem_we, bus.i_wnext, bus.d_wnext,
             bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done};
    n_cmp++; if (flags !== 10'd0) begin n_err++; $display("FAIL reset_flags got %b exp 0", flags); end
    n_cmp++; if (bus.mem_addr !== 32'd0) begin n_err++; $display("FAIL reset_addr got %h exp 0", bus.mem_addr); end
    n_cmp++; if (bus.mem_din !== 32'd0) begin n_err++; $display("FAIL reset_din got %h exp 0", bus.mem_din); end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if ({bus.i_gnt, bus.d_gnt, bus.mem_cs} !== 3'd0) begin n_err++; $display("FAIL idle_no_req got %b exp 000", {bus.i_gnt, bus.d_gnt, bus.mem_cs}); end
    model_last = 1'b0;
  endtask

  task automatic test_single_read();
    bit to; int t0;
    clear_logs(); ack_mode = 0;
    tick(); t0 = cyc;
    bus.d_we = 1'b0; bus.d_addr = 32'h0000_1234; bus.d_req = 1'b1;
    wait_dones(1, 40, to);
    bus.d_req = 1'b0; repeat (3) tick();
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL rd_timeout got no done exp done"); end
    n_cmp++; if (beats.size() != 4) begin n_err++; $display("FAIL rd_beats got %0d exp 4", beats.size()); end
    for (int k = 0; k < beats.size() && k < 4; k++) begin
      n_cmp++;
      if (beats[k].addr !== 32'h0000_1230 + 32'(4 * k) || beats[k].we !== 1'b0 || beats[k].port !== 1'b1 || beats[k].cyc != t0 + 2 + 2 * k) begin
        n_err++; $display("FAIL rd_beat%0d got addr=%h we=%b port=%b cyc=%0d exp addr=%h we=0 port=1 cyc=%0d",
                          k, beats[k].addr, beats[k].we, beats[k].port, beats[k].cyc - t0, 32'h0000_1230 + 32'(4 * k), 2 + 2 * k);
      end
    end
    n_cmp++; if (rvs.size() != 4) begin n_err++; $display("FAIL rd_rvalid_cnt got %0d exp 4", rvs.size()); end
    for (int k = 0; k < rvs.size() && k < beats.size(); k++) begin
      n_cmp++;
      if (rvs[k].data !== beats[k].data || rvs[k].port !== 1'b1 || rvs[k].cyc != beats[k].cyc) begin
        n_err++; $display("FAIL rd_data%0d got %h port=%b exp %h port=1", k, rvs[k].data, rvs[k].port, beats[k].data);
      end
    end
    n_cmp++; if (dones.size() != 1 || dones[0].cyc != t0 + 9 || dones[0].port !== 1'b1) begin
      n_err++; $display("FAIL rd_done got n=%0d cyc=%0d exp n=1 cyc=9 port D", dones.size(), dones.size() > 0 ? dones[0].cyc - t0 : -1);
    end
    n_cmp++; if (gnts.size() != 1 || gnts[0].port !== 1'b1 || gnts[0].cyc != t0 + 1) begin
      n_err++; $display("FAIL rd_gnt got n=%0d exp single D grant at cycle 1", gnts.size());
    end
    model_last = 1'b1;
  endtask

  task automatic test_write_stall();
    bit to;
    clear_logs(); ack_mode = 1; cs_cnt = 0;
    tick();
    for (int k = 0; k < 4; k++) i_words[k] = $urandom;
    i_idx = 0; bus.i_wdata = i_words[0];
    bus.i_we = 1'b1; bus.i_addr = 32'h0000_0040; bus.i_req = 1'b1;
    wait_dones(1, 100, to);
    bus.i_req = 1'b0; bus.i_we = 1'b0; repeat (3) tick();
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL wr_timeout got no done exp done"); end
    n_cmp++; if (beats.size() != 4) begin n_err++; $display("FAIL wr_acks got %0d exp 4", beats.size()); end
    for (int k = 0; k < beats.size() && k < 4; k++) begin
      n_cmp++;
      if (beats[k].addr !== 32'h0000_0040 + 32'(4 * k) || beats[k].we !== 1'b1 || beats[k].port !== 1'b0 || beats[k].data !== i_words[k]) begin
        n_err++; $display("FAIL wr_beat%0d got addr=%h we=%b din=%h exp addr=%h we=1 din=%h",
                          k, beats[k].addr, beats[k].we, beats[k].data, 32'h0000_0040 + 32'(4 * k), i_words[k]);
      end
    end
    n_cmp++; if (wns.size() != 4 || rvs.size() != 0) begin n_err++; $display("FAIL wr_strobes got wnext=%0d rvalid=%0d exp 4/0", wns.size(), rvs.size()); end
    n_cmp++; if (dones.size() != 1 || dones[0].port !== 1'b0) begin n_err++; $display("FAIL wr_done got n=%0d exp 1 on I", dones.size()); end
    model_last = 1'b0;
  endtask

  task automatic run_tie();
    bit to1, to2, first;
    logic [31:0] a_i, a_d, a_exp;
`ifdef ARB_RR_EN
    first = ~model_last;
`else
    first = 1'b1;
`endif
    clear_logs(); ack_mode = 2;
    tick();
    a_i = $urandom; a_d = $urandom;
    bus.i_we = 1'b0; bus.d_we = 1'b0; bus.i_addr = a_i; bus.d_addr = a_d;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    wait_dones(1, 200, to1);
    if (first) bus.d_req = 1'b0; else bus.i_req = 1'b0;
    wait_dones(2, 200, to2);
    bus.i_req = 1'b0; bus.d_req = 1'b0; repeat (3) tick();
    n_cmp++; if ((to1 | to2) !== 1'b0) begin n_err++; $display("FAIL tie_timeout got %b%b exp 00", to1, to2); end
    n_cmp++; if (dones.size() != 2 || dones[0].port !== first || dones[1].port !== ~first) begin
      n_err++; $display("FAIL tie_order got n=%0d first=%b exp n=2 first=%b", dones.size(), dones.size() > 0 ? dones[0].port : 1'bx, first);
    end
    n_cmp++; if (gnts.size() != 2 || dones.size() < 1 || gnts[1].cyc != dones[0].cyc + 2) begin
      n_err++; $display("FAIL tie_regrant got %0d cycles after done exp 2", (gnts.size() > 1 && dones.size() > 0) ? gnts[1].cyc - dones[0].cyc : -1);
    end
    n_cmp++; if (beats.size() != 8 || rvs.size() != 8) begin n_err++; $display("FAIL tie_beats got %0d/%0d exp 8/8", beats.size(), rvs.size()); end
    for (int k = 0; k < beats.size() && k < 8; k++) begin
      a_exp = beat_addr(((k < 4) == first) ? a_d : a_i, k % 4);
      n_cmp++;
      if (beats[k].addr !== a_exp || beats[k].port !== ((k < 4) ? first : ~first)) begin
        n_err++; $display("FAIL tie_beat%0d got addr=%h port=%b exp addr=%h", k, beats[k].addr, beats[k].port, a_exp);
      end
    end
    model_last = ~first;
  endtask

  task automatic test_tie();
    bit to;
    run_tie();
    run_tie();
    clear_logs(); ack_mode = 0;
    tick();
    bus.d_we = 1'b0; bus.d_addr = $urandom; bus.d_req = 1'b1;
    wait_dones(1, 40, to);
    bus.d_req = 1'b0; repeat (2) tick();
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL lone_d_timeout got no done exp done"); end
    model_last = 1'b1;
    run_tie();
  endtask

  task automatic test_wrap();
    bit to;
    clear_logs(); ack_mode = 2;
    tick();
    bus.d_we = 1'b0; bus.d_addr = 32'hFFFF_FFF4; bus.d_req = 1'b1;
    wait_dones(1, 200, to);
    bus.d_req = 1'b0; repeat (3) tick();
    n_cmp++; if (to !== 1'b0 || beats.size() != 4) begin n_err++; $display("FAIL wrap_beats got %0d exp 4", beats.size()); end
    for (int k = 0; k < beats.size() && k < 4; k++) begin
      n_cmp++;
      if (beats[k].addr !== 32'hFFFF_FFF0 + 32'(4 * k)) begin
        n_err++; $display("FAIL wrap_addr%0d got %h exp %h", k, beats[k].addr, 32'hFFFF_FFF0 + 32'(4 * k));
      end
    end
    model_last = 1'b1;
  endtask

  task automatic test_req_drop();
    bit to1, to2; logic [31:0] a;
    clear_logs(); ack_mode = 0;
    tick();
    a = $urandom;
    bus.d_we = 1'b0; bus.d_addr = a; bus.d_req = 1'b1;
    wait_beats(1, 40, to1);
    bus.d_req = 1'b0;
    wait_dones(1, 40, to2);
    repeat (5) tick();
    n_cmp++; if ((to1 | to2) !== 1'b0 || beats.size() != 4 || dones.size() != 1) begin
      n_err++; $display("FAIL drop_burst got beats=%0d dones=%0d exp 4/1", beats.size(), dones.size());
    end
    for (int k = 0; k < beats.size() && k < 4; k++) begin
      n_cmp++; if (beats[k].addr !== beat_addr(a, k)) begin n_err++; $display("FAIL drop_addr%0d got %h exp %h", k, beats[k].addr, beat_addr(a, k)); end
    end
    model_last = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit to; logic [9:0] flags; logic [31:0] a;
    clear_logs(); ack_mode = 0;
    tick();
    bus.d_we = 1'b0; bus.d_addr = $urandom; bus.d_req = 1'b1;
    wait_beats(2, 40, to);
    rst = 1'b1; bus.d_req = 1'b0;
    tick();
    @(negedge clk);
    flags = {bus.i_gnt, bus.d_gnt, bus.mem_cs, bus.mem_we, bus.i_wnext, bus.d_wnext,
             bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done};
    n_cmp++; if (to !== 1'b0 || flags !== 10'd0 || bus.mem_addr !== 32'd0) begin
      n_err++; $display("FAIL midrst_outputs got %b addr=%h exp 0", flags, bus.mem_addr);
    end
    tick(); rst = 1'b0;
    repeat (4) tick();
    n_cmp++; if (dones.size() != 0 || beats.size() != 2) begin n_err++; $display("FAIL midrst_abandon got dones=%0d beats=%0d exp 0/2", dones.size(), beats.size()); end
    model_last = 1'b0;
    clear_logs();
    a = $urandom;
    bus.i_we = 1'b0; bus.i_addr = a; bus.i_req = 1'b1;
    wait_dones(1, 40, to);
    bus.i_req = 1'b0; repeat (3) tick();
    n_cmp++; if (to !== 1'b0 || beats.size() != 4 || beats[0].addr !== beat_addr(a, 0) || beats[0].port !== 1'b0) begin
      n_err++; $display("FAIL midrst_restart got beats=%0d first=%h exp 4 first=%h", beats.size(), beats.size() > 0 ? beats[0].addr : 32'd0, beat_addr(a, 0));
    end
  endtask

  task automatic test_random();
    bit to, port, we; logic [31:0] a, exp_d;
    logic [31:0] w[4];
    for (int n = 0; n < 8; n++) begin
      clear_logs(); ack_mode = 2;
      tick();
      port = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1)); a = $urandom;
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      if (port) begin
        d_words = w; d_idx = 0; bus.d_wdata = w[0]; bus.d_we = we; bus.d_addr = a; bus.d_req = 1'b1;
      end else begin
        i_words = w; i_idx = 0; bus.i_wdata = w[0]; bus.i_we = we; bus.i_addr = a; bus.i_req = 1'b1;
      end
      wait_dones(1, 200, to);
      bus.i_req = 1'b0; bus.d_req = 1'b0; repeat (2) tick();
      n_cmp++; if (to !== 1'b0 || beats.size() != 4 || dones.size() != 1 || dones[0].port !== port) begin
        n_err++; $display("FAIL rnd%0d_burst got beats=%0d dones=%0d exp 4/1", n, beats.size(), dones.size());
      end
      for (int k = 0; k < beats.size() && k < 4; k++) begin
        exp_d = we ? w[k] : ((k < rvs.size()) ? rvs[k].data : 32'hDEAD_BEEF);
        n_cmp++;
        if (beats[k].addr !== beat_addr(a, k) || beats[k].we !== we || beats[k].port !== port || beats[k].data !== exp_d) begin
          n_err++; $display("FAIL rnd%0d_beat%0d got addr=%h we=%b data=%h exp addr=%h we=%b data=%h",
                            n, k, beats[k].addr, beats[k].we, beats[k].data, beat_addr(a, k), we, exp_d);
        end
      end
      model_last = port;
    end
  endtask

  task automatic test_invariants();
    n_cmp++; if (viol != 0) begin n_err++; $display("FAIL ownership_invariants got %0d violations exp 0", viol); end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = 32'd0; bus.i_wdata = 32'd0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
    bus.mem_dout = 32'd0; bus.mem_ack = 1'b0;
    test_reset();
    test_single_read();
    test_write_stall();
    test_tie();
    test_wrap();
    test_req_drop();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
